sprite_layer_renderer: RTL and testbench
========================================

Name: sprite_layer_renderer

Overview:
- Pipelined, frame-synchronised successor to the combinational colour mapper; sits between the VGA controller (DrawX/DrawY) and the RGB output pins.
- Draws one 8x16 doodle sprite over NUM_PLAT platforms, each PLAT_TILES tiles of 16x4 pixels wide, from synchronous sprite ROMs.
- Per-frame position snapshots give tear-free updates.
- Reports opaque-pixel collisions between doodle and platforms to game logic once per frame.

Parameters:
- NUM_PLAT, 8, number of platform slots.
- PLAT_TILES, 5, tiles per platform: tile 0 left cap, 1..PLAT_TILES-2 middle, PLAT_TILES-1 right cap; legal range 2..8.
- DOODLE_X0, 320, reset doodle X.
- DOODLE_Y0, 240, reset doodle Y.
- DOODLE_RGB, 24'h00FFFF, doodle colour.
- PLAT_RGB, 24'hFFFF00, platform colour.
- BG_RGB, 24'hFFFFFF, background colour.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  DrawX/DrawY is in the active region this cycle.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- doodle_x  in  10  pending doodle X (upper-left corner).
- doodle_y  in  10  pending doodle Y (upper-left corner).
- plat_we  in  1  write strobe for a pending platform entry.
- plat_idx  in  $clog2(NUM_PLAT)  entry index.
- plat_x  in  10  platform X.
- plat_y  in  10  platform Y.
- plat_en  in  1  entry visible.
- Red  out  8  pixel red.
- Green  out  8  pixel green.
- Blue  out  8  pixel blue.
- rgb_valid  out  1  pix_valid delayed 2 cycles.
- collide  out  1  previous frame had a doodle/platform opaque overlap.
- collide_idx  out  $clog2(NUM_PLAT)  lowest platform index that collided in the previous frame.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - Red/Green/Blue = 0, rgb_valid = 0, collide = 0, collide_idx = 0.
  - All pending and active platform entries cleared (en=0, x=0, y=0).
  - Active doodle position = (DOODLE_X0, DOODLE_Y0).
  - Pipeline registers and sticky collision state cleared.
  - Reset mid-frame aborts the frame; the first frame_start after release starts normal operation.
- Pending table:
  - plat_we writes {plat_x, plat_y, plat_en} into pending[plat_idx] at the clock edge.
  - plat_idx >= NUM_PLAT: write ignored.
- Commit on frame_start:
  - Active table <= pending table; active doodle <= doodle_x/doodle_y.
  - A plat_we in the same cycle as frame_start is not included in this commit; it is committed at the next frame_start.
  - collide/collide_idx <= sticky state; sticky state cleared.
  - If a sticky update and frame_start coincide, the update belongs to the new frame.
- Stage 1 (cycle 0 -> registered at edge 1):
  - Hit tests use 11-bit zero-extended arithmetic so X+width never wraps. Platforms may extend past X=639 with no wrap.
  - Doodle hit: doodle_x <= DrawX < doodle_x+8 and doodle_y <= DrawY < doodle_y+16. Doodle ROM address = 16*2 + (DrawY-doodle_y).
  - Platform k hit: en_k and plat_x_k <= DrawX < plat_x_k+16*PLAT_TILES and plat_y_k <= DrawY < plat_y_k+4.
    - tile = (DrawX-plat_x_k)>>4, tile code 0/1/2 for left/middle/right.
    - Platform ROM address = 4*code + (DrawY-plat_y_k).
  - Winning platform = lowest hit index.
  - Stage 1 registers: hit flags, column offsets, winning index, pix_valid.
- Stage 2 (edge 2): ROMs return registered data.
  - Opacity, MSB = leftmost pixel: doodle bit [7-col]; platform bit [15-(col mod 16)].
- Colour priority: doodle opaque -> DOODLE_RGB; else platform opaque -> PLAT_RGB; else BG_RGB.
  - When the stage-1 pix_valid was 0, output is 0.
  - Output is registered; latency from DrawX/DrawY to RGB = 2 cycles.
- Collision: doodle opaque and platform opaque on the same valid pixel sets sticky collide.
  - Sticky index records the minimum index that collided this frame.
- No back-pressure; a new pixel is accepted every cycle.

Decomposition:
- Shared package render_pkg holds:
  - plat_entry_t struct {x[9:0], y[9:0], en}.
  - Constants TILE_W=16, TILE_H=4, DOODLE_W=8, DOODLE_H=16, DOODLE_ROM_BASE=32.
  - Tile codes TILE_L=0, TILE_M=1, TILE_R=2.
  - An rgb_t struct.
- Sub-module platform_table: pending/active register arrays, commit on frame_start, NUM_PLAT-way hit test and priority encoder to the winning index/row/column.
- The sprite ROMs are the existing synchronous ROM blocks.

Test Plan:
- Reset, one frame_start, DrawX=320, DrawY=240 with an opaque doodle row/col -> 2 cycles later RGB = 00,FF,FF and rgb_valid=1; pixel (0,0) -> FF,FF,FF.
- Write idx0 = (240,470,en=1), no frame_start, scan (240,470) -> background; after frame_start -> FF,FF,00 on opaque bits.
- Check tile codes: same pixel offsets at X=240 (code 0), 256 (1), 304 (2) -> ROM addresses 0+row, 4+row, 8+row.
- Platforms 3 and 1 overlapping at (100,100) -> colour from entry 1's bit. Doodle moved onto it -> doodle wins, collide=1 and collide_idx=1 after the next frame_start; one frame later with no overlap -> collide=0.
- Platform at x=620 -> pixels 620..639 drawn, no wrap artefact at X=0..79.
- plat_we coincident with frame_start -> not visible this frame, visible after the next frame_start.
- Reset_n asserted mid-line -> all outputs 0 immediately; platform table empty afterwards.
- idx=NUM_PLAT write -> ignored.

Source files
------------

// File: rtl/render_pkg.sv
// Shared geometry, entry/colour types and the sprite bitmaps used by the sprite layer renderer.
package render_pkg;

  localparam int TILE_W          = 16;
  localparam int TILE_H          = 4;
  localparam int DOODLE_W        = 8;
  localparam int DOODLE_H        = 16;
  localparam int DOODLE_ROM_BASE = 32;

  typedef enum logic [1:0] {
    TILE_L = 2'd0,
    TILE_M = 2'd1,
    TILE_R = 2'd2
  } tile_code_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } plat_entry_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Doodle bitmap, MSB is the leftmost pixel; the facing-right frame lives at rows 32..47.
  function automatic logic [7:0] doodle_rom_word(input logic [5:0] addr);
    case (addr)
      6'd32: return 8'hFC;
      6'd33: return 8'h7E;
      6'd34: return 8'h3C;
      6'd35: return 8'hFF;
      6'd36: return 8'hDB;
      6'd37: return 8'h81;
      6'd38: return 8'h66;
      6'd39: return 8'h5A;
      6'd40: return 8'h18;
      6'd41: return 8'hA5;
      6'd42: return 8'hC3;
      6'd43: return 8'hE7;
      6'd44: return 8'h99;
      6'd45: return 8'h3C;
      6'd46: return 8'h7E;
      6'd47: return 8'h24;
      default: return 8'h00;
    endcase
  endfunction

  // Platform tiles: four rows each for left cap, middle and right cap.
  function automatic logic [15:0] plat_rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:  return 16'h8FFF;
      4'd1:  return 16'hFFFF;
      4'd2:  return 16'h7FFE;
      4'd3:  return 16'h3FFC;
      4'd4:  return 16'hFFFF;
      4'd5:  return 16'hAAAA;
      4'd6:  return 16'h5555;
      4'd7:  return 16'hF0F0;
      4'd8:  return 16'hFFF1;
      4'd9:  return 16'hFFFE;
      4'd10: return 16'h7FFF;
      4'd11: return 16'h3FFC;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sprite_layer_renderer_if.sv
// Pixel, position-update and colour/collision signals between the game side and the renderer.
interface sprite_layer_renderer_if #(
  parameter int NUM_PLAT = 8
);
  localparam int IDX_W = $clog2(NUM_PLAT);

  logic             frame_start;
  logic             pix_valid;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [9:0]       doodle_x;
  logic [9:0]       doodle_y;
  logic             plat_we;
  logic [IDX_W-1:0] plat_idx;
  logic [9:0]       plat_x;
  logic [9:0]       plat_y;
  logic             plat_en;
  logic [7:0]       Red;
  logic [7:0]       Green;
  logic [7:0]       Blue;
  logic             rgb_valid;
  logic             collide;
  logic [IDX_W-1:0] collide_idx;

  modport master (
    output frame_start, pix_valid, DrawX, DrawY, doodle_x, doodle_y,
           plat_we, plat_idx, plat_x, plat_y, plat_en,
    input  Red, Green, Blue, rgb_valid, collide, collide_idx
  );

  modport slave (
    input  frame_start, pix_valid, DrawX, DrawY, doodle_x, doodle_y,
           plat_we, plat_idx, plat_x, plat_y, plat_en,
    output Red, Green, Blue, rgb_valid, collide, collide_idx
  );
endinterface

// File: rtl/platform_table.sv
// Pending/active platform slots with frame commit, per-slot hit test and lowest-index winner select.
module platform_table
  import render_pkg::*;
#(
  parameter int NUM_PLAT   = 8,
  parameter int PLAT_TILES = 5,
  parameter int IDX_W      = $clog2(NUM_PLAT)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_start_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  plat_entry_t      wr_entry_i,
  input  logic [9:0]       draw_x_i,
  input  logic [9:0]       draw_y_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic [3:0]       rom_addr_o,
  output logic [3:0]       col_o
);
  localparam logic [10:0] SPAN_W = 11'(TILE_W * PLAT_TILES);
  localparam logic [10:0] SPAN_H = 11'(TILE_H);

  logic [NUM_PLAT-1:0] hit;
  logic [3:0]          addr [NUM_PLAT];
  logic [3:0]          col  [NUM_PLAT];
  logic [10:0]         dx;
  logic [10:0]         dy;

  // 11-bit compares so a platform hanging past X=639 never wraps to the left edge.
  assign dx = {1'b0, draw_x_i};
  assign dy = {1'b0, draw_y_i};

  genvar gi;
  for (gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
    plat_entry_t pend_q;
    plat_entry_t act_q;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] off_x;
    logic [1:0]  row;
    logic [6:0]  tile;
    tile_code_t  code;

    // Out-of-range indices match no slot, so those writes fall on the floor.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        pend_q <= '0;
        act_q  <= '0;
      end else begin
        if (frame_start_i) act_q <= pend_q;
        if (we_i && idx_i == IDX_W'(gi)) pend_q <= wr_entry_i;
      end
    end

    assign x0      = {1'b0, act_q.x};
    assign y0      = {1'b0, act_q.y};
    assign off_x   = dx - x0;
    assign row     = 2'(dy - y0);
    assign tile    = off_x[10:4];
    assign hit[gi] = act_q.en && (dx >= x0) && (dx < x0 + SPAN_W)
                              && (dy >= y0) && (dy < y0 + SPAN_H);

    always_comb begin
      if (tile == 7'd0)                    code = TILE_L;
      else if (tile == 7'(PLAT_TILES - 1)) code = TILE_R;
      else                                 code = TILE_M;
    end

    assign addr[gi] = {code, row};
    assign col[gi]  = off_x[3:0];
  end

  always_comb begin
    hit_o      = 1'b0;
    win_idx_o  = '0;
    rom_addr_o = '0;
    col_o      = '0;
    for (int k = NUM_PLAT - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_o      = 1'b1;
        win_idx_o  = IDX_W'(k);
        rom_addr_o = addr[k];
        col_o      = col[k];
      end
    end
  end
endmodule

// File: rtl/sprite_layer_renderer.sv
// Two-stage pixel pipeline: hit test + ROM fetch, then opacity/priority colour and per-frame collision report.
module sprite_layer_renderer
  import render_pkg::*;
#(
  parameter int          NUM_PLAT   = 8,
  parameter int          PLAT_TILES = 5,
  parameter logic [9:0]  DOODLE_X0  = 10'd320,
  parameter logic [9:0]  DOODLE_Y0  = 10'd240,
  parameter logic [23:0] DOODLE_RGB = 24'h00FFFF,
  parameter logic [23:0] PLAT_RGB   = 24'hFFFF00,
  parameter logic [23:0] BG_RGB     = 24'hFFFFFF
) (
  input logic                   Clk,
  input logic                   Reset_n,
  sprite_layer_renderer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PLAT);

  logic [9:0]       dood_x_q, dood_y_q;
  logic [10:0]      dx, dy, dx0, dy0;
  logic             dood_hit;
  logic [2:0]       dood_col;
  logic [3:0]       dood_row;
  logic [5:0]       dood_addr;
  logic             plat_hit;
  logic [IDX_W-1:0] plat_win;
  logic [3:0]       plat_addr, plat_col;
  plat_entry_t      wr_entry;

  logic             s1_valid_q, s1_dhit_q, s1_phit_q;
  logic [2:0]       s1_dcol_q;
  logic [3:0]       s1_pcol_q;
  logic [IDX_W-1:0] s1_pidx_q;
  logic [7:0]       dood_data_q;
  logic [15:0]      plat_data_q;

  logic             dood_opq, plat_opq, coll_now;
  rgb_t             rgb_d, rgb_q;
  logic             rgb_valid_q, collide_q, sticky_q;
  logic [IDX_W-1:0] collide_idx_q, sticky_idx_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dood_x_q <= DOODLE_X0;
      dood_y_q <= DOODLE_Y0;
    end else if (bus.frame_start) begin
      dood_x_q <= bus.doodle_x;
      dood_y_q <= bus.doodle_y;
    end
  end

  assign dx        = {1'b0, bus.DrawX};
  assign dy        = {1'b0, bus.DrawY};
  assign dx0       = {1'b0, dood_x_q};
  assign dy0       = {1'b0, dood_y_q};
  assign dood_hit  = (dx >= dx0) && (dx < dx0 + 11'(DOODLE_W))
                  && (dy >= dy0) && (dy < dy0 + 11'(DOODLE_H));
  assign dood_col  = 3'(bus.DrawX - dood_x_q);
  assign dood_row  = 4'(bus.DrawY - dood_y_q);
  assign dood_addr = 6'(DOODLE_ROM_BASE) + {2'b00, dood_row};
  assign wr_entry  = {bus.plat_x, bus.plat_y, bus.plat_en};

  platform_table #(
    .NUM_PLAT  (NUM_PLAT),
    .PLAT_TILES(PLAT_TILES),
    .IDX_W     (IDX_W)
  ) u_table (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start_i(bus.frame_start),
    .we_i         (bus.plat_we),
    .idx_i        (bus.plat_idx),
    .wr_entry_i   (wr_entry),
    .draw_x_i     (bus.DrawX),
    .draw_y_i     (bus.DrawY),
    .hit_o        (plat_hit),
    .win_idx_o    (plat_win),
    .rom_addr_o   (plat_addr),
    .col_o        (plat_col)
  );

  // Synchronous ROM reads line up with the stage-1 registers below.
  always_ff @(posedge Clk) begin
    dood_data_q <= doodle_rom_word(dood_addr);
    plat_data_q <= plat_rom_word(plat_addr);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_dhit_q  <= 1'b0;
      s1_phit_q  <= 1'b0;
      s1_dcol_q  <= '0;
      s1_pcol_q  <= '0;
      s1_pidx_q  <= '0;
    end else begin
      s1_valid_q <= bus.pix_valid;
      s1_dhit_q  <= dood_hit;
      s1_phit_q  <= plat_hit;
      s1_dcol_q  <= dood_col;
      s1_pcol_q  <= plat_col;
      s1_pidx_q  <= plat_win;
    end
  end

  // Inverting the column picks bit [W-1-col]: MSB is the leftmost pixel.
  assign dood_opq = s1_dhit_q & dood_data_q[~s1_dcol_q];
  assign plat_opq = s1_phit_q & plat_data_q[~s1_pcol_q];
  assign coll_now = s1_valid_q & dood_opq & plat_opq;

  always_comb begin
    rgb_d = '0;
    if (s1_valid_q) begin
      if (dood_opq)      rgb_d = rgb_t'(DOODLE_RGB);
      else if (plat_opq) rgb_d = rgb_t'(PLAT_RGB);
      else               rgb_d = rgb_t'(BG_RGB);
    end
  end

  // A hit landing on the frame_start edge is counted in the frame that starts there.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q         <= '0;
      rgb_valid_q   <= 1'b0;
      collide_q     <= 1'b0;
      collide_idx_q <= '0;
      sticky_q      <= 1'b0;
      sticky_idx_q  <= '0;
    end else begin
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_valid_q;
      if (bus.frame_start) begin
        collide_q     <= sticky_q;
        collide_idx_q <= sticky_idx_q;
        sticky_q      <= coll_now;
        sticky_idx_q  <= coll_now ? s1_pidx_q : '0;
      end else if (coll_now && (!sticky_q || s1_pidx_q < sticky_idx_q)) begin
        sticky_q     <= 1'b1;
        sticky_idx_q <= s1_pidx_q;
      end
    end
  end

  assign bus.Red         = rgb_q.r;
  assign bus.Green       = rgb_q.g;
  assign bus.Blue        = rgb_q.b;
  assign bus.rgb_valid   = rgb_valid_q;
  assign bus.collide     = collide_q;
  assign bus.collide_idx = collide_idx_q;
endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Randomised bench for sprite_layer_renderer, checked against a pixel-level model of the drawing rules.
module tb_sprite_layer_renderer;
  localparam int NP = 6;
  localparam int PT = 5;
  localparam int IW = $clog2(NP);

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  sprite_layer_renderer_if #(.NUM_PLAT(NP)) bus ();

  sprite_layer_renderer #(.NUM_PLAT(NP), .PLAT_TILES(PT)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  logic [7:0]  drom [16] = '{8'hFC, 8'h7E, 8'h3C, 8'hFF, 8'hDB, 8'h81, 8'h66, 8'h5A,
                             8'h18, 8'hA5, 8'hC3, 8'hE7, 8'h99, 8'h3C, 8'h7E, 8'h24};
  logic [15:0] prom [12] = '{16'h8FFF, 16'hFFFF, 16'h7FFE, 16'h3FFC,
                             16'hFFFF, 16'hAAAA, 16'h5555, 16'hF0F0,
                             16'hFFF1, 16'hFFFE, 16'h7FFF, 16'h3FFC};

  int  m_px [NP], m_py [NP], m_ax [NP], m_ay [NP];
  bit  m_pen [NP], m_aen [NP];
  int  m_pdx, m_pdy, m_dx, m_dy, m_sidx, m_cidx;
  bit  m_sticky, m_coll;
  int  checks = 0;
  int  errors = 0;

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) begin
      m_px[k] = 0; m_py[k] = 0; m_pen[k] = 0;
      m_ax[k] = 0; m_ay[k] = 0; m_aen[k] = 0;
    end
    m_dx = 320; m_dy = 240;
    m_sticky = 0; m_sidx = 0; m_coll = 0; m_cidx = 0;
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < NP; k++) begin
      m_ax[k] = m_px[k]; m_ay[k] = m_py[k]; m_aen[k] = m_pen[k];
    end
    m_dx = m_pdx; m_dy = m_pdy;
    m_coll = m_sticky; m_cidx = m_sticky ? m_sidx : 0;
    m_sticky = 0; m_sidx = 0;
  endfunction

  function automatic void model_pix(input int x, input int y, output logic [23:0] rgb,
                                    output bit coll, output int cidx);
    bit d_op = 0;
    bit p_op = 0;
    int w = -1;
    int t, code, ox;
    if (x >= m_dx && x < m_dx + 8 && y >= m_dy && y < m_dy + 16)
      d_op = drom[y - m_dy][7 - (x - m_dx)];
    for (int k = 0; k < NP; k++) begin
      if (w < 0 && m_aen[k] && x >= m_ax[k] && x < m_ax[k] + 16 * PT &&
          y >= m_ay[k] && y < m_ay[k] + 4) begin
        w    = k;
        ox   = x - m_ax[k];
        t    = ox / 16;
        code = (t == 0) ? 0 : ((t == PT - 1) ? 2 : 1);
        p_op = prom[code * 4 + (y - m_ay[k])][15 - (ox % 16)];
      end
    end
    rgb  = d_op ? 24'h00FFFF : (p_op ? 24'hFFFF00 : 24'hFFFFFF);
    coll = d_op && p_op;
    cidx = w;
  endfunction

  function automatic void model_hit(input int x, input int y, input bit v, output logic [23:0] e);
    bit c;
    int ci;
    model_pix(x, y, e, c, ci);
    if (!v) e = 24'h0;
    if (v && c) begin
      if (!m_sticky || ci < m_sidx) m_sidx = ci;
      m_sticky = 1;
    end
  endfunction

  task automatic set_doodle(input int x, input int y);
    bus.doodle_x = 10'(x); bus.doodle_y = 10'(y);
    m_pdx = x; m_pdy = y;
  endtask

  task automatic do_frame_start();
    bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
    model_commit();
  endtask

  task automatic write_plat(input int idx, input int x, input int y, input bit en, input bit with_fs);
    bus.plat_we = 1'b1; bus.plat_idx = IW'(idx);
    bus.plat_x = 10'(x); bus.plat_y = 10'(y); bus.plat_en = en;
    bus.frame_start = with_fs;
    @(negedge Clk);
    bus.plat_we = 1'b0; bus.frame_start = 1'b0;
    if (with_fs) model_commit();
    if (idx < NP) begin m_px[idx] = x; m_py[idx] = y; m_pen[idx] = en; end
  endtask

  task automatic pixel(input int x, input int y, input bit v,
                       output logic [23:0] got, output logic gv, output logic [23:0] e);
    model_hit(x, y, v, e);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pix_valid = v;
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    @(negedge Clk);
    got = {bus.Red, bus.Green, bus.Blue};
    gv  = bus.rgb_valid;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    bus.frame_start = 0; bus.pix_valid = 0; bus.DrawX = 0; bus.DrawY = 0;
    bus.plat_we = 0; bus.plat_idx = 0; bus.plat_x = 0; bus.plat_y = 0; bus.plat_en = 0;
    set_doodle(320, 240);
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    got = {bus.Red, bus.Green, bus.Blue};
    checks++; if (got !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %06h expected 000000", got); end
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_rgb_valid: got %b expected 0", bus.rgb_valid); end
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL reset_collide: got %b expected 0", bus.collide); end
    checks++; if (bus.collide_idx !== '0) begin errors++; $display("FAIL reset_collide_idx: got %0d expected 0", bus.collide_idx); end
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  task automatic test_doodle();
    logic [23:0] got, e;
    logic gv;
    int x, y;
    do_frame_start();
    pixel(320, 240, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'h00FFFF) begin errors++; $display("FAIL doodle_origin: got %06h expected %06h", got, e); end
    checks++; if (gv !== 1'b1) begin errors++; $display("FAIL doodle_valid: got %b expected 1", gv); end
    pixel(0, 0, 1, got, gv, e);
    checks++; if (got !== e) begin errors++; $display("FAIL background_00: got %06h expected %06h", got, e); end
    pixel(320, 240, 0, got, gv, e);
    checks++; if (got !== e || gv !== 1'b0) begin errors++; $display("FAIL invalid_pixel: got %06h/%b expected %06h/0", got, gv, e); end
    for (int i = 0; i < 8; i++) begin
      x = 318 + int'($urandom_range(0, 11)); y = 238 + int'($urandom_range(0, 19));
      pixel(x, y, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL doodle_rand (%0d,%0d): got %06h expected %06h", x, y, got, e); end
    end
  endtask

  task automatic test_platform_commit();
    logic [23:0] got, e;
    logic gv;
    int xb [3] = '{240, 256, 304};
    int cols [4] = '{0, 1, 5, 15};
    int x, y;
    write_plat(0, 240, 470, 1, 0);
    pixel(240, 470, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'hFFFFFF) begin errors++; $display("FAIL plat_precommit: got %06h expected %06h", got, e); end
    do_frame_start();
    foreach (xb[t]) for (int r = 0; r < 4; r++) foreach (cols[c]) begin
      pixel(xb[t] + cols[c], 470 + r, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL tile_code (%0d,%0d): got %06h expected %06h", xb[t] + cols[c], 470 + r, got, e); end
    end
    for (int i = 0; i < 10; i++) begin
      x = 230 + int'($urandom_range(0, 100)); y = 466 + int'($urandom_range(0, 10));
      pixel(x, y, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL plat_rand (%0d,%0d): got %06h expected %06h", x, y, got, e); end
    end
  endtask

  task automatic test_overlap_collision();
    logic [23:0] got, e;
    logic gv;
    int x, y;
    set_doodle(500, 20);
    write_plat(3, 92, 101, 1, 0);
    write_plat(1, 100, 100, 1, 0);
    do_frame_start();
    for (int i = 0; i < 20; i++) begin
      x = 90 + int'($urandom_range(0, 30)); y = 99 + int'($urandom_range(0, 6));
      pixel(x, y, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL overlap_prio (%0d,%0d): got %06h expected %06h", x, y, got, e); end
    end
    set_doodle(100, 100);
    do_frame_start();
    checks++; if (bus.collide !== m_coll) begin errors++; $display("FAIL collide_none: got %b expected %b", bus.collide, m_coll); end
    for (int yy = 104; yy >= 100; yy--) for (int xx = 100; xx < 108; xx++) begin
      pixel(xx, yy, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL doodle_on_plat (%0d,%0d): got %06h expected %06h", xx, yy, got, e); end
    end
    do_frame_start();
    checks++; if (bus.collide !== 1'b1 || m_coll !== 1'b1) begin errors++; $display("FAIL collide_set: got %b expected 1", bus.collide); end
    checks++; if (bus.collide_idx !== IW'(m_cidx) || m_cidx != 1) begin errors++; $display("FAIL collide_idx: got %0d expected 1", bus.collide_idx); end
    pixel(0, 0, 1, got, gv, e);
    do_frame_start();
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL collide_clear: got %b expected 0", bus.collide); end
  endtask

  task automatic test_edge_wrap();
    logic [23:0] got, e;
    logic gv;
    set_doodle(500, 20);
    write_plat(2, 620, 300, 1, 0);
    do_frame_start();
    for (int y = 300; y < 304; y++) for (int x = 612; x < 640; x++) begin
      pixel(x, y, 1, got, gv, e);
      checks++; if (got !== e) begin errors++; $display("FAIL right_edge (%0d,%0d): got %06h expected %06h", x, y, got, e); end
    end
    for (int y = 300; y < 302; y++) for (int x = 0; x < 80; x++) begin
      pixel(x, y, 1, got, gv, e);
      checks++; if (got !== e || got !== 24'hFFFFFF) begin errors++; $display("FAIL no_wrap (%0d,%0d): got %06h expected FFFFFF", x, y, got); end
    end
  endtask

  task automatic test_we_with_frame_start();
    logic [23:0] got, e;
    logic gv;
    write_plat(4, 400, 200, 1, 1);
    pixel(400, 200, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'hFFFFFF) begin errors++; $display("FAIL we_fs_hidden: got %06h expected %06h", got, e); end
    do_frame_start();
    pixel(400, 200, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'hFFFF00) begin errors++; $display("FAIL we_fs_visible: got %06h expected %06h", got, e); end
  endtask

  task automatic test_idx_oob();
    logic [23:0] got, e;
    logic gv;
    write_plat(NP, 50, 50, 1, 0);
    write_plat(NP + 1, 50, 60, 1, 0);
    do_frame_start();
    pixel(50, 50, 1, got, gv, e);
    checks++; if (got !== 24'hFFFFFF || e !== 24'hFFFFFF) begin errors++; $display("FAIL idx_oob_a: got %06h expected FFFFFF", got); end
    pixel(55, 61, 1, got, gv, e);
    checks++; if (got !== 24'hFFFFFF || e !== 24'hFFFFFF) begin errors++; $display("FAIL idx_oob_b: got %06h expected FFFFFF", got); end
    pixel(240, 470, 1, got, gv, e);
    checks++; if (got !== e) begin errors++; $display("FAIL idx_oob_slot0: got %06h expected %06h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_q [$];
    bit          expv_q [$];
    logic [23:0] e, got, eq;
    bit          v, evq;
    int          x, y;
    int          n = 300;
    set_doodle(104, 98);
    do_frame_start();
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        eq = exp_q.pop_front(); evq = expv_q.pop_front();
        got = {bus.Red, bus.Green, bus.Blue};
        checks++; if (got !== eq || bus.rgb_valid !== evq) begin errors++; $display("FAIL stream[%0d]: got %06h/%b expected %06h/%b", i - 2, got, bus.rgb_valid, eq, evq); end
      end
      if (i < n) begin
        if ($urandom_range(0, 1) == 0) begin
          x = 90 + int'($urandom_range(0, 90)); y = 95 + int'($urandom_range(0, 20));
        end else begin
          x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
        end
        v = ($urandom_range(0, 7) != 0);
        model_hit(x, y, v, e);
        exp_q.push_back(e); expv_q.push_back(v);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pix_valid = v;
      end else begin
        bus.pix_valid = 1'b0;
      end
      @(negedge Clk);
    end
    do_frame_start();
    checks++; if (bus.collide !== m_coll) begin errors++; $display("FAIL stream_collide: got %b expected %b", bus.collide, m_coll); end
    checks++; if (bus.collide_idx !== IW'(m_cidx)) begin errors++; $display("FAIL stream_collide_idx: got %0d expected %0d", bus.collide_idx, m_cidx); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got, e;
    logic gv;
    for (int i = 0; i < 3; i++) begin
      bus.DrawX = 10'(100 + i); bus.DrawY = 10'd100; bus.pix_valid = 1'b1;
      @(negedge Clk);
    end
    #2 Reset_n = 1'b0;
    #1;
    got = {bus.Red, bus.Green, bus.Blue};
    checks++; if (got !== 24'h0 || bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL midreset_rgb: got %06h/%b expected 000000/0", got, bus.rgb_valid); end
    checks++; if (bus.collide !== 1'b0 || bus.collide_idx !== '0) begin errors++; $display("FAIL midreset_collide: got %b/%0d expected 0/0", bus.collide, bus.collide_idx); end
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    do_frame_start();
    pixel(240, 470, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'hFFFFFF) begin errors++; $display("FAIL midreset_table0: got %06h expected %06h", got, e); end
    pixel(400, 200, 1, got, gv, e);
    checks++; if (got !== e || e !== 24'hFFFFFF) begin errors++; $display("FAIL midreset_table4: got %06h expected %06h", got, e); end
    pixel(104, 98, 1, got, gv, e);
    checks++; if (got !== e) begin errors++; $display("FAIL midreset_doodle: got %06h expected %06h", got, e); end
  endtask

  initial begin
    test_reset();
    test_doodle();
    test_platform_commit();
    test_overlap_collision();
    test_edge_wrap();
    test_we_with_frame_start();
    test_idx_oob();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
